// File: rtl/score_accumulator.sv
// Song-level score/health accumulator: folds per-note results from the scoring
// stage into running totals, tracks health and reports song completion or failure.
`ifndef MAX_NUM
`define MAX_NUM 16
`endif

module score_accumulator #(
   parameter int HP_MAX       = 100,
   parameter int MISS_PENALTY = 10,
   parameter int HEAL         = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          mod,
   input  logic [`MAX_NUM-1:0] total_note,
   input  logic                hit_valid,
   input  logic [`MAX_NUM-1:0] base_score,
   input  logic [`MAX_NUM-1:0] bonus_score,
   input  logic [`MAX_NUM-1:0] combo,
   input  logic [`MAX_NUM-1:0] acc,
   input  logic [2:0]          level,
   output logic [`MAX_NUM-1:0] last_combo,
   output logic [`MAX_NUM-1:0] last_base_score,
   output logic [`MAX_NUM-1:0] now_cnt,
   output logic [`MAX_NUM-1:0] total_score,
   output logic [`MAX_NUM-1:0] max_combo,
   output logic [`MAX_NUM-1:0] miss_cnt,
   output logic [6:0]          hp,
   output logic [2:0]          final_level,
   output logic [1:0]          state,
   output logic                done,
   output logic                failed
);

   localparam int W = `MAX_NUM;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } state_t;

   // Health never exceeds 127, so larger penalties/heals behave identically when clamped.
   localparam logic [6:0] HP_FULL = 7'(HP_MAX);
   localparam logic [7:0] PEN     = 8'((MISS_PENALTY > 127) ? 127 : MISS_PENALTY);
   localparam logic [7:0] GAIN    = 8'((HEAL > 127) ? 127 : HEAL);

   state_t       state_reg;
   logic [1:0]   mod_reg;
   logic [W-1:0] total_note_reg;
   logic [W-1:0] last_combo_reg, last_base_reg, now_cnt_reg;
   logic [W-1:0] total_score_reg, max_combo_reg, miss_cnt_reg;
   logic [6:0]   hp_reg;
   logic [2:0]   final_level_reg;
   logic         done_reg, failed_reg;

   logic         hit_accept;
   logic         is_miss;
   logic [W:0]   base_sum;
   logic [W:0]   hit_sum;
   logic [W+1:0] total_sum;
   logic [7:0]   hp_heal;
   logic [6:0]   hp_next;
   logic [W-1:0] now_cnt_next;
   logic [W-1:0] last_base_next;
   logic [W-1:0] total_score_next;

   // acc is carried for display in the scoring stage only.
   logic unused_ok;
   assign unused_ok = ^acc;

   always_comb begin
      hit_accept   = hit_valid && !start && (state_reg == PLAY);
      is_miss      = (base_score == '0);
      now_cnt_next = now_cnt_reg + W'(1);
      base_sum     = {1'b0, last_base_reg} + {1'b0, base_score};
      hit_sum      = {1'b0, base_score} + {1'b0, bonus_score};
      total_sum    = {2'b00, total_score_reg} + {1'b0, hit_sum};
      last_base_next   = base_sum[W] ? '1 : base_sum[W-1:0];
      total_score_next = (total_sum[W+1:W] != 2'b00) ? '1 : total_sum[W-1:0];
      hp_heal      = {1'b0, hp_reg} + GAIN;
      hp_next      = hp_reg;
      if (is_miss) begin
         if (mod_reg != 2'b01)
            hp_next = ({1'b0, hp_reg} > PEN) ? 7'({1'b0, hp_reg} - PEN) : 7'd0;
      end else begin
         hp_next = (hp_heal >= {1'b0, HP_FULL}) ? HP_FULL : hp_heal[6:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         mod_reg         <= 2'b00;
         total_note_reg  <= '0;
         last_combo_reg  <= '0;
         last_base_reg   <= '0;
         now_cnt_reg     <= '0;
         total_score_reg <= '0;
         max_combo_reg   <= '0;
         miss_cnt_reg    <= '0;
         hp_reg          <= HP_FULL;
         final_level_reg <= 3'd0;
         done_reg        <= 1'b0;
         failed_reg      <= 1'b0;
      end else if (start) begin
         mod_reg         <= mod;
         total_note_reg  <= total_note;
         last_combo_reg  <= '0;
         last_base_reg   <= '0;
         now_cnt_reg     <= '0;
         total_score_reg <= '0;
         max_combo_reg   <= '0;
         miss_cnt_reg    <= '0;
         hp_reg          <= HP_FULL;
         final_level_reg <= 3'd0;
         failed_reg      <= 1'b0;
         if (total_note == '0) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
         end else begin
            state_reg <= PLAY;
            done_reg  <= 1'b0;
         end
      end else if (hit_accept) begin
         now_cnt_reg     <= now_cnt_next;
         last_combo_reg  <= combo;
         last_base_reg   <= last_base_next;
         total_score_reg <= total_score_next;
         if (combo > max_combo_reg)
            max_combo_reg <= combo;
         if (is_miss)
            miss_cnt_reg <= miss_cnt_reg + W'(1);
         hp_reg <= hp_next;
         // Running out of health on the last note still counts as a failure.
         if (hp_next == 7'd0) begin
            state_reg  <= FAIL;
            failed_reg <= 1'b1;
         end else if (now_cnt_next == total_note_reg) begin
            state_reg       <= DONE;
            done_reg        <= 1'b1;
            final_level_reg <= level;
         end
      end
   end

   assign last_combo      = last_combo_reg;
   assign last_base_score = last_base_reg;
   assign now_cnt         = now_cnt_reg;
   assign total_score     = total_score_reg;
   assign max_combo       = max_combo_reg;
   assign miss_cnt        = miss_cnt_reg;
   assign hp              = hp_reg;
   assign final_level     = final_level_reg;
   assign state           = state_reg;
   assign done            = done_reg;
   assign failed          = failed_reg;

endmodule

// File: tb/tb_score_accumulator.sv
// Scoreboard bench for score_accumulator: driver pushes reference snapshots,
// a negedge monitor pops and compares them against the DUT.
`ifndef MAX_NUM
`define MAX_NUM 16
`endif

module tb_score_accumulator;

   localparam int W      = `MAX_NUM;
   localparam int MAXV   = (1 << W) - 1;
   localparam int HP_MAX = 100;
   localparam int PEN    = 10;
   localparam int HEAL   = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   mod = 2'b00;
   logic [W-1:0] total_note = '0;
   logic         hit_valid = 1'b0;
   logic [W-1:0] base_score = '0, bonus_score = '0, combo = '0, acc = '0;
   logic [2:0]   level = 3'd0;
   logic [W-1:0] last_combo, last_base_score, now_cnt, total_score, max_combo, miss_cnt;
   logic [6:0]   hp;
   logic [2:0]   final_level;
   logic [1:0]   state;
   logic         done, failed;

   score_accumulator #(.HP_MAX(HP_MAX), .MISS_PENALTY(PEN), .HEAL(HEAL)) dut (
      .clk(clk), .rst(rst), .start(start), .mod(mod), .total_note(total_note),
      .hit_valid(hit_valid), .base_score(base_score), .bonus_score(bonus_score),
      .combo(combo), .acc(acc), .level(level),
      .last_combo(last_combo), .last_base_score(last_base_score), .now_cnt(now_cnt),
      .total_score(total_score), .max_combo(max_combo), .miss_cnt(miss_cnt),
      .hp(hp), .final_level(final_level), .state(state), .done(done), .failed(failed)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st; int hp; int now; int lcombo; int lbase; int total;
      int maxc; int miss; int flevel; int done; int failed;
   } snap_t;

   snap_t exp_q[$];
   int n_pass = 0;
   int n_total = 0;

   // Reference model: song state as plain integers (0 idle, 1 play, 2 done, 3 fail).
   int m_st = 0, m_hp = HP_MAX, m_now = 0, m_lcombo = 0, m_lbase = 0, m_total = 0;
   int m_maxc = 0, m_miss = 0, m_flevel = 0, m_mod = 0, m_tn = 0;

   function automatic void check(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   function automatic void model_clear();
      m_hp = HP_MAX; m_now = 0; m_lcombo = 0; m_lbase = 0; m_total = 0;
      m_maxc = 0; m_miss = 0; m_flevel = 0;
   endfunction

   function automatic void model_step(bit r, bit s, int m, int tn, bit hv,
                                      int b, int bo, int c, int lv);
      if (r) begin
         m_st = 0; model_clear();
      end else if (s) begin
         m_mod = m; m_tn = tn; model_clear();
         m_st = (tn == 0) ? 2 : 1;
      end else if (hv && m_st == 1) begin
         m_now    = (m_now + 1) % (MAXV + 1);
         m_lcombo = c;
         m_lbase  = (m_lbase + b > MAXV) ? MAXV : m_lbase + b;
         m_total  = (m_total + b + bo > MAXV) ? MAXV : m_total + b + bo;
         if (c > m_maxc) m_maxc = c;
         if (b == 0) begin
            m_miss++;
            if (m_mod != 1) m_hp = (m_hp > PEN) ? m_hp - PEN : 0;
         end else begin
            m_hp = (m_hp + HEAL > HP_MAX) ? HP_MAX : m_hp + HEAL;
         end
         if (m_hp == 0) m_st = 3;
         else if (m_now == m_tn) begin m_st = 2; m_flevel = lv; end
      end
   endfunction

   function automatic snap_t snapshot();
      snap_t e;
      e.st = m_st; e.hp = m_hp; e.now = m_now; e.lcombo = m_lcombo; e.lbase = m_lbase;
      e.total = m_total; e.maxc = m_maxc; e.miss = m_miss; e.flevel = m_flevel;
      e.done = (m_st == 2) ? 1 : 0; e.failed = (m_st == 3) ? 1 : 0;
      return e;
   endfunction

   task automatic cycle(bit r, bit s, int m, int tn, bit hv, int b, int bo, int c, int lv);
      @(negedge clk);
      rst = r; start = s; mod = 2'(m); total_note = W'(tn); hit_valid = hv;
      base_score = W'(b); bonus_score = W'(bo); combo = W'(c); level = 3'(lv);
      acc = W'($urandom);
      model_step(r, s, m, tn, hv, b, bo, c, lv);
      #1 exp_q.push_back(snapshot());
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      snap_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("state", int'(state), e.st);
         check("hp", int'(hp), e.hp);
         check("now_cnt", int'(now_cnt), e.now);
         check("last_combo", int'(last_combo), e.lcombo);
         check("last_base_score", int'(last_base_score), e.lbase);
         check("total_score", int'(total_score), e.total);
         check("max_combo", int'(max_combo), e.maxc);
         check("miss_cnt", int'(miss_cnt), e.miss);
         check("final_level", int'(final_level), e.flevel);
         check("done", int'(done), e.done);
         check("failed", int'(failed), e.failed);
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "bench timeout");
   end

   initial begin : driver
      int r, s, hv, b, bo, tn;
      // Reset
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("reset_state", int'(state), 0);
      check("reset_hp", int'(hp), HP_MAX);

      // Basic three-note song
      cycle(0, 1, 0, 3, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 320, 32, 2, 5);
      cycle(0, 0, 0, 0, 1, 300, 32, 3, 5);
      cycle(0, 0, 0, 0, 1, 200, 16, 0, 5);
      settle();
      check("basic_now_cnt", int'(now_cnt), 3);
      check("basic_last_base", int'(last_base_score), 820);
      check("basic_total", int'(total_score), 900);
      check("basic_max_combo", int'(max_combo), 3);
      check("basic_last_combo", int'(last_combo), 0);
      check("basic_done", int'(done), 1);
      check("basic_final_level", int'(final_level), 5);
      idle();

      // Ten misses in Normal mode
      cycle(0, 1, 0, 20, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 7, 0, 1);
      settle();
      check("fail_failed", int'(failed), 1);
      check("fail_hp", int'(hp), 0);
      check("fail_miss_cnt", int'(miss_cnt), 10);
      cycle(0, 0, 0, 0, 1, 50, 0, 4, 1);
      settle();
      check("fail_ignored_now", int'(now_cnt), 10);
      check("fail_ignored_state", int'(state), 3);

      // Ten misses in No Fail mode
      cycle(0, 1, 1, 20, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0, 2);
      settle();
      check("nofail_hp", int'(hp), HP_MAX);
      check("nofail_state", int'(state), 1);
      check("nofail_miss_cnt", int'(miss_cnt), 10);

      // Saturation of scores and health cap
      cycle(0, 1, 0, 10, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 40000, 30000, i + 1, 3);
      settle();
      check("sat_total", int'(total_score), MAXV);
      check("sat_last_base", int'(last_base_score), MAXV);
      check("sat_hp", int'(hp), HP_MAX);

      // Start and hit together, then rst and start together
      cycle(0, 0, 1, 9, 1, 100, 0, 1, 0);
      cycle(0, 1, 0, 5, 1, 100, 50, 9, 0);
      settle();
      check("coll_now", int'(now_cnt), 0);
      check("coll_total", int'(total_score), 0);
      check("coll_state", int'(state), 1);
      cycle(1, 1, 0, 5, 1, 100, 0, 1, 0);
      settle();
      check("rst_start_state", int'(state), 0);

      // Empty song
      cycle(0, 1, 2, 0, 0, 0, 0, 0, 0);
      settle();
      check("empty_state", int'(state), 2);
      check("empty_done", int'(done), 1);
      check("empty_final_level", int'(final_level), 0);

      // Randomised play
      for (int i = 0; i < 2500; i++) begin
         r  = ($urandom_range(0, 99) < 2) ? 1 : 0;
         s  = ($urandom_range(0, 99) < 5) ? 1 : 0;
         hv = ($urandom_range(0, 99) < 70) ? 1 : 0;
         tn = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 25);
         case ($urandom_range(0, 3))
            0:       b = 0;
            1:       b = $urandom_range(0, MAXV);
            default: b = $urandom_range(1, 1000);
         endcase
         bo = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 200);
         cycle(r[0], s[0], $urandom_range(0, 3), tn, hv[0], b, bo,
               $urandom_range(0, 300), $urandom_range(0, 7));
      end
      idle();
      idle();
      repeat (2) @(negedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
